uncache_bridge: RTL and testbench

Converts one uncached CPU data access (`no_dcache` = 1, kseg1) at a time into a single-beat AXI read or write, and returns the result on the CPU's sram-like handshake. Sits between the MMU's physical data address and the AXI crossbar, beside the D-cache. It is the path that carries MMIO and other uncached traffic. It holds one outstanding request.

---
 rtl/uncache_bridge.sv | 232 +++++++++++++++++++++++
 tb/tb_uncache_bridge.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_bridge.sv
// uncache_bridge: turns one uncached CPU data access at a time into a single-beat
// AXI read or write and returns completion on the sram-like CPU handshake.
// One request is outstanding at most; addr_ok is low until it completes.
//
// Handshake rule used on every AXI channel here: a transfer happens on a rising
// clock edge where both valid and ready are high. A valid, once raised, stays
// high with its payload unchanged until that edge, and drops the cycle after.
module uncache_bridge (
  input  logic        clk,
  input  logic        rst,
  // CPU sram-like side
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic [31:0] cpu_data_rdata,
  // AXI read address / data
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / data / response
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  // current FSM state, for debug and checker binding
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;

  // latched request payload
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  // registered AXI valid/ready outputs
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;

  // per-channel completion flags for the write address and write data channels
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  // byte strobes for the incoming request; size 3 behaves like a word
  logic [3:0]  strb_calc;
  // write channel finished either earlier or on this edge
  logic        aw_fin, w_fin;

  // Compute byte-lane strobes from the request size and low address bits.
  always_comb begin
    strb_calc = 4'b1111;
    case (cpu_data_size)
      2'd0:    strb_calc = 4'b0001 << cpu_data_addr[1:0];
      2'd1:    strb_calc = cpu_data_addr[1] ? 4'b1100 : 4'b0011;
      default: strb_calc = 4'b1111;
    endcase
  end

  // Next-state, next-output and combinational CPU handshake logic.
  always_comb begin
    state_d          = state_q;
    size_d           = size_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    wstrb_d          = wstrb_q;
    arvalid_d        = arvalid_q;
    rready_d         = rready_q;
    awvalid_d        = awvalid_q;
    wvalid_d         = wvalid_q;
    bready_d         = bready_q;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
    aw_fin           = 1'b0;
    w_fin            = 1'b0;
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;

    case (state_q)
      S_IDLE: begin
        cpu_data_addr_ok = 1'b1;
        if (cpu_data_req) begin
          size_d  = cpu_data_size;
          addr_d  = cpu_data_addr;
          wdata_d = cpu_data_wdata;
          wstrb_d = strb_calc;
          if (cpu_data_wr) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      S_RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        // rlast is ignored: every read is a single beat
        if (rvalid) begin
          cpu_data_data_ok = 1'b1;
          rready_d         = 1'b0;
          state_d          = S_IDLE;
        end
      end

      S_WR_REQ: begin
        // AW and W complete independently, in any order or together
        aw_fin = aw_done_q | (awvalid_q & awready);
        w_fin  = w_done_q  | (wvalid_q & wready);
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        // bresp is ignored: errors are not reported to the CPU
        if (bvalid) begin
          cpu_data_data_ok = 1'b1;
          bready_d         = 1'b0;
          state_d          = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Addresses go out exactly as given; no alignment is applied.
  assign araddr         = addr_q;
  assign arlen          = 8'd0;
  assign arsize         = {1'b0, size_q};
  assign arvalid        = arvalid_q;
  assign rready         = rready_q;
  assign awaddr         = addr_q;
  assign awlen          = 8'd0;
  assign awsize         = {1'b0, size_q};
  assign awvalid        = awvalid_q;
  assign wdata          = wdata_q;
  assign wstrb          = wstrb_q;
  assign wlast          = 1'b1;
  assign wvalid         = wvalid_q;
  assign bready         = bready_q;
  assign cpu_data_rdata = rdata;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_uncache_bridge.sv
// Bench for uncache_bridge: a transaction-level model of the bridge plus an AXI
// slave with programmable or random stalls, directed scenarios and a random run.
module tb_uncache_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_data_req;
  logic        cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic [31:0] cpu_data_rdata;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [2:0]  dbg_state;

  uncache_bridge dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_data_req     (cpu_data_req),
    .cpu_data_wr      (cpu_data_wr),
    .cpu_data_size    (cpu_data_size),
    .cpu_data_addr    (cpu_data_addr),
    .cpu_data_wdata   (cpu_data_wdata),
    .cpu_data_addr_ok (cpu_data_addr_ok),
    .cpu_data_data_ok (cpu_data_data_ok),
    .cpu_data_rdata   (cpu_data_rdata),
    .araddr           (araddr),
    .arlen            (arlen),
    .arsize           (arsize),
    .arvalid          (arvalid),
    .arready          (arready),
    .rdata            (rdata),
    .rvalid           (rvalid),
    .rready           (rready),
    .awaddr           (awaddr),
    .awlen            (awlen),
    .awsize           (awsize),
    .awvalid          (awvalid),
    .awready          (awready),
    .wdata            (wdata),
    .wstrb            (wstrb),
    .wlast            (wlast),
    .wvalid           (wvalid),
    .wready           (wready),
    .bvalid           (bvalid),
    .bready           (bready),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int cyc;

  // ---------------- model of the bridge ----------------
  logic        busy;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        ar_done, aw_done, w_done;
  logic [31:0] exp_q[$];   // write data expected on the W channel, in order

  int acc_cnt, dok_cnt;
  // slave stall settings
  logic random_dly;
  int dir_ar, dir_r, dir_aw, dir_w, dir_b;
  int ar_dly, r_dly, aw_dly, w_dly, b_dly;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic        force_rdata_en;
  logic [31:0] force_rdata;

  // captured DUT values at handshakes, compared against literals
  int          cap_acc_cyc, cap_dok_cyc, cap_ar_cyc, cap_aw_cyc, cap_w_cyc, cap_br_cyc;
  logic [31:0] cap_araddr, cap_rdata, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [7:0]  cap_arlen;
  logic [3:0]  cap_wstrb;
  logic        cap_wlast;

  function automatic logic [3:0] exp_strb(input logic [1:0] s, input logic [31:0] a);
    logic [3:0] one;
    one = 4'b0001;
    if (s == 2'd0) return one << a[1:0];
    if (s == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Compare DUT outputs for this cycle against the model, then advance the model
  // by the events that take effect on the coming rising edge.
  task automatic step();
    logic e_arv, e_rr, e_awv, e_wv, e_br, e_dok, was_idle;
    cyc++;
    was_idle = !busy;
    e_arv = busy && !m_wr && !ar_done;
    e_rr  = busy && !m_wr && ar_done;
    e_awv = busy && m_wr && !aw_done;
    e_wv  = busy && m_wr && !w_done;
    e_br  = busy && m_wr && aw_done && w_done;
    e_dok = (e_rr && rvalid) || (e_br && bvalid);
    if (!rst) begin
      chk("addr_ok", cpu_data_addr_ok, was_idle);
      chk("data_ok", cpu_data_data_ok, e_dok);
      chk("arvalid", arvalid, e_arv);
      chk("rready", rready, e_rr);
      chk("awvalid", awvalid, e_awv);
      chk("wvalid", wvalid, e_wv);
      chk("bready", bready, e_br);
      if (e_arv) begin
        chk("araddr", araddr, m_addr);
        chk("arsize", arsize, {1'b0, m_size});
        chk("arlen", arlen, 0);
      end
      if (e_awv) begin
        chk("awaddr", awaddr, m_addr);
        chk("awsize", awsize, {1'b0, m_size});
        chk("awlen", awlen, 0);
      end
      if (e_wv) begin
        chk("wdata", wdata, m_wdata);
        chk("wstrb", wstrb, exp_strb(m_size, m_addr));
        chk("wlast", wlast, 1);
      end
      if (e_dok && !m_wr) chk("cpu_rdata", cpu_data_rdata, rdata);
      if (e_wv && wready) begin
        if (exp_q.size() == 0) chk("wdata_sb_empty", 1, 0);
        else chk("wdata_sb", wdata, exp_q.pop_front());
      end
      // captures for literal checks
      if (e_arv && arready) begin
        cap_ar_cyc = cyc; cap_araddr = araddr; cap_arsize = arsize; cap_arlen = arlen;
      end
      if (e_awv && awready) begin cap_aw_cyc = cyc; cap_awsize = awsize; end
      if (e_wv && wready) begin
        cap_w_cyc = cyc; cap_wstrb = wstrb; cap_wlast = wlast; cap_wdata = wdata;
      end
      if (e_dok) begin cap_dok_cyc = cyc; cap_rdata = cpu_data_rdata; end
      if (bready && cap_br_cyc < 0) cap_br_cyc = cyc;
    end
    if (rst) begin
      busy = 1'b0; ar_done = 1'b0; aw_done = 1'b0; w_done = 1'b0;
      exp_q.delete();
    end else begin
      if (e_arv && arready) ar_done = 1'b1;
      if (e_awv && awready) aw_done = 1'b1;
      if (e_wv && wready)   w_done  = 1'b1;
      if (e_dok) begin busy = 1'b0; dok_cnt++; end
      if (was_idle && cpu_data_req) begin
        busy = 1'b1; m_wr = cpu_data_wr; m_size = cpu_data_size;
        m_addr = cpu_data_addr; m_wdata = cpu_data_wdata;
        ar_done = 1'b0; aw_done = 1'b0; w_done = 1'b0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        cap_acc_cyc = cyc; cap_br_cyc = -1;
        acc_cnt++;
        if (cpu_data_wr) exp_q.push_back(cpu_data_wdata);
        if (random_dly) begin
          ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
          aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
          b_dly = $urandom_range(0, 3);
        end else begin
          ar_dly = dir_ar; r_dly = dir_r; aw_dly = dir_aw; w_dly = dir_w; b_dly = dir_b;
        end
      end
    end
  endtask

  // AXI slave: each response goes high after its programmed number of eligible cycles.
  task automatic drive_slave();
    logic el;
    el = busy && !m_wr && !ar_done;
    arready = el && (ar_cnt >= ar_dly); if (el) ar_cnt++;
    el = busy && !m_wr && ar_done;
    rvalid = el && (r_cnt >= r_dly); if (el) r_cnt++;
    rdata = force_rdata_en ? force_rdata : $urandom();
    el = busy && m_wr && !aw_done;
    awready = el && (aw_cnt >= aw_dly); if (el) aw_cnt++;
    el = busy && m_wr && !w_done;
    wready = el && (w_cnt >= w_dly); if (el) w_cnt++;
    el = busy && m_wr && aw_done && w_done;
    bvalid = el && (b_cnt >= b_dly); if (el) b_cnt++;
  endtask

  // One clock: check at the falling edge, then drive after the rising edge.
  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
    drive_slave();
  endtask

  task automatic set_dly(input int a, input int r, input int aw, input int w, input int b);
    random_dly = 1'b0;
    dir_ar = a; dir_r = r; dir_aw = aw; dir_w = w; dir_b = b;
  endtask

  // Issue one request with req held until accepted, then wait for completion.
  task automatic run_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd);
    int n;
    int acc0;
    acc0 = acc_cnt;
    dok_cnt = 0;
    cpu_data_req = 1'b1; cpu_data_wr = wr; cpu_data_size = size;
    cpu_data_addr = addr; cpu_data_wdata = wd;
    n = 0;
    while (acc_cnt == acc0 && n < 20) begin tick(); n++; end
    cpu_data_req = 1'b0;
    chk("accept_timeout", acc_cnt, acc0 + 1);
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    chk("complete_timeout", busy, 0);
    chk("dok_count", dok_cnt, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    chk("drain_timeout", busy, 0);
  endtask

  int a1, d1, n;

  // ---------------- main sequence ----------------
  initial begin
    checks = 0; failures = 0; cyc = 0;
    busy = 1'b0; m_wr = 1'b0; m_size = 2'd0; m_addr = 32'd0; m_wdata = 32'd0;
    ar_done = 1'b0; aw_done = 1'b0; w_done = 1'b0;
    acc_cnt = 0; dok_cnt = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    set_dly(0, 0, 0, 0, 0);
    force_rdata_en = 1'b0; force_rdata = 32'd0;
    cap_br_cyc = -1;
    rst = 1'b1;
    cpu_data_req = 1'b0; cpu_data_wr = 1'b0; cpu_data_size = 2'd0;
    cpu_data_addr = 32'd0; cpu_data_wdata = 32'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    tick(); tick();
    // reset state
    chk("rst_addr_ok", cpu_data_addr_ok, 1);
    chk("rst_data_ok", cpu_data_data_ok, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wstrb", wstrb, 0);
    rst = 1'b0;
    tick();

    // read word, zero-wait slave
    force_rdata_en = 1'b1; force_rdata = 32'hDEAD_BEEF;
    run_txn(1'b0, 2'd2, 32'h1FAF_F000, 32'd0);
    chk("rd_araddr", cap_araddr, 32'h1FAF_F000);
    chk("rd_arsize", cap_arsize, 3'd2);
    chk("rd_arlen", cap_arlen, 8'd0);
    chk("rd_rdata", cap_rdata, 32'hDEAD_BEEF);
    chk("rd_latency", cap_dok_cyc - cap_acc_cyc, 2);
    force_rdata_en = 1'b0;

    // byte write, zero-wait
    run_txn(1'b1, 2'd0, 32'h1FAF_F003, 32'hAB00_0000);
    chk("bw_wstrb", cap_wstrb, 4'b1000);
    chk("bw_awsize", cap_awsize, 3'd0);
    chk("bw_wlast", cap_wlast, 1);
    chk("bw_wdata", cap_wdata, 32'hAB00_0000);
    chk("bw_latency", cap_dok_cyc - cap_acc_cyc, 2);

    // half write, zero-wait, then with awready three cycles after wready
    run_txn(1'b1, 2'd1, 32'h1FAF_F002, 32'h1234_0000);
    chk("hw_wstrb", cap_wstrb, 4'b1100);
    set_dly(0, 0, 3, 0, 0);
    run_txn(1'b1, 2'd1, 32'h1FAF_F002, 32'h5678_0000);
    chk("hw_aw_after_w", cap_aw_cyc - cap_w_cyc, 3);
    chk("hw_bready_start", cap_br_cyc, cap_aw_cyc + 1);
    chk("hw2_wstrb", cap_wstrb, 4'b1100);

    // read with arready stalled 4 cycles and rvalid 2 cycles
    set_dly(4, 2, 0, 0, 0);
    run_txn(1'b0, 2'd2, 32'h1FAF_F010, 32'd0);
    chk("st_ar_cycle", cap_ar_cyc - cap_acc_cyc, 5);
    chk("st_latency", cap_dok_cyc - cap_acc_cyc, 8);
    chk("st_araddr", cap_araddr, 32'h1FAF_F010);

    // back-to-back: req held across a read then a write
    set_dly(0, 0, 0, 0, 0);
    dok_cnt = 0;
    a1 = acc_cnt;
    cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_size = 2'd2;
    cpu_data_addr = 32'h1FAF_F020; cpu_data_wdata = 32'd0;
    n = 0;
    while (acc_cnt == a1 && n < 20) begin tick(); n++; end
    chk("b2b_acc1", acc_cnt, a1 + 1);
    a1 = cap_acc_cyc;
    cpu_data_wr = 1'b1; cpu_data_size = 2'd2;
    cpu_data_addr = 32'h1FAF_F024; cpu_data_wdata = 32'hCAFE_F00D;
    n = 0;
    while (dok_cnt == 0 && n < 20) begin tick(); n++; end
    chk("b2b_dok1", dok_cnt, 1);
    d1 = cap_dok_cyc;
    chk("b2b_rd_latency", d1 - a1, 2);
    n = 0;
    while (cap_acc_cyc == a1 && n < 20) begin tick(); n++; end
    chk("b2b_second_accept", cap_acc_cyc, d1 + 1);
    cpu_data_req = 1'b0;
    wait_idle();

    // reset while waiting for the write response
    set_dly(0, 0, 0, 0, 10);
    a1 = acc_cnt;
    cpu_data_req = 1'b1; cpu_data_wr = 1'b1; cpu_data_size = 2'd2;
    cpu_data_addr = 32'h1FAF_F030; cpu_data_wdata = 32'h0BAD_0BAD;
    n = 0;
    while (acc_cnt == a1 && n < 20) begin tick(); n++; end
    cpu_data_req = 1'b0;
    n = 0;
    while (!(busy && aw_done && w_done) && n < 20) begin tick(); n++; end
    chk("rs_reached_resp", busy && aw_done && w_done, 1);
    chk("rs_bready_before", bready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_addr_ok", cpu_data_addr_ok, 1);
    chk("rs_bready", bready, 0);
    chk("rs_awvalid", awvalid, 0);
    chk("rs_wvalid", wvalid, 0);
    chk("rs_data_ok", cpu_data_data_ok, 0);
    tick(); tick();

    // randomized traffic with random slave stalls
    random_dly = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cpu_data_req   = ($urandom_range(0, 2) != 0);
      cpu_data_wr    = $urandom_range(0, 1);
      cpu_data_size  = $urandom_range(0, 3);
      cpu_data_addr  = $urandom();
      cpu_data_wdata = $urandom();
      tick();
    end
    cpu_data_req = 1'b0;
    wait_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
